pipe_stage_reg: RTL and testbench

Parametrised Y86-64 pipeline stage register, the general successor to the fixed memory-to-writeback latch. It carries the full instruction context (stat, icode, ifun, cnd, rA, rB and a packed bank of 64-bit value fields) between any two pipeline stages. It adds stall (hold) and bubble (NOP insert) control, a valid flag, and halt freezing on an exceptional status. One instance sits between each adjacent pair of stages (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_reg.sv | 193 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised Y86-64 pipeline stage register
//
// Purpose:
//    Carries one instruction's context (stat, icode, ifun, cnd, rA, rB and a
//    packed bank of value fields) from one pipeline stage to the next.
//    Supports stall (hold), bubble (NOP insert), a valid flag, and freezes
//    the stage once a non-AOK status has been captured.
//
// Ports:
//    clk, rst             - stage clock (rising edge), async active-high reset
//    stall_in, bubble_in  - hold contents / load a NOP bubble
//    stat_in .. vals_in   - incoming instruction context
//    stat_out .. vals_out - registered instruction context
//    valid_out            - 1 when a real instruction is held
//    halted_out           - stage frozen after a non-AOK status
//    ctl_err_out          - sticky flag: stall and bubble requested together
//    stall_cnt_out        - saturating stall-cycle counter
//    bubble_cnt_out       - saturating bubble counter
//
// Optional feature macro: PIPE_PERF_CNT_EN
//    Defined   - stall/bubble counters are built.
//    Undefined - no counter registers; both counter ports read 0.

module pipe_stage_reg #(
   parameter int         DATA_W       = 64,
   parameter int         NUM_VAL      = 6,
   parameter int         REG_W        = 4,
   parameter logic [3:0] BUBBLE_ICODE = 4'h1,
   parameter logic [2:0] STAT_AOK     = 3'd1,
   parameter int         CNT_W        = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall_in,
   input  logic                      bubble_in,
   input  logic [2:0]                stat_in,
   input  logic [3:0]                icode_in,
   input  logic [3:0]                ifun_in,
   input  logic                      cnd_in,
   input  logic [REG_W-1:0]          rA_in,
   input  logic [REG_W-1:0]          rB_in,
   input  logic [NUM_VAL*DATA_W-1:0] vals_in,
   output logic [2:0]                stat_out,
   output logic [3:0]                icode_out,
   output logic [3:0]                ifun_out,
   output logic                      cnd_out,
   output logic [REG_W-1:0]          rA_out,
   output logic [REG_W-1:0]          rB_out,
   output logic [NUM_VAL*DATA_W-1:0] vals_out,
   output logic                      valid_out,
   output logic                      halted_out,
   output logic                      ctl_err_out,
   output logic [CNT_W-1:0]          stall_cnt_out,
   output logic [CNT_W-1:0]          bubble_cnt_out
);

   localparam int VW = NUM_VAL * DATA_W;

   logic [2:0]       stat_q,  stat_d;
   logic [3:0]       icode_q, icode_d;
   logic [3:0]       ifun_q,  ifun_d;
   logic             cnd_q,   cnd_d;
   logic [REG_W-1:0] rA_q,    rA_d;
   logic [REG_W-1:0] rB_q,    rB_d;
   logic [VW-1:0]    vals_q,  vals_d;
   logic             valid_q, valid_d;
   logic             halted_q, halted_d;
   logic             ctl_err_q, ctl_err_d;

   // Control decode shared by payload and counters; priority is
   // halt > stall > bubble > normal load.
   logic do_stall, do_bubble, do_load;

   always_comb begin
      do_stall  = !halted_q && stall_in;
      do_bubble = !halted_q && !stall_in && bubble_in;
      do_load   = !halted_q && !stall_in && !bubble_in;
   end

   always_comb begin
      stat_d    = stat_q;
      icode_d   = icode_q;
      ifun_d    = ifun_q;
      cnd_d     = cnd_q;
      rA_d      = rA_q;
      rB_d      = rB_q;
      vals_d    = vals_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      ctl_err_d = ctl_err_q;

      if (do_stall && bubble_in) begin
         ctl_err_d = 1'b1;
      end

      if (do_bubble) begin
         stat_d  = STAT_AOK;
         icode_d = BUBBLE_ICODE;
         ifun_d  = '0;
         cnd_d   = 1'b0;
         rA_d    = '0;
         rB_d    = '0;
         vals_d  = '0;
         valid_d = 1'b0;
      end

      if (do_load) begin
         stat_d  = stat_in;
         icode_d = icode_in;
         ifun_d  = ifun_in;
         cnd_d   = cnd_in;
         rA_d    = rA_in;
         rB_d    = rB_in;
         vals_d  = vals_in;
         valid_d = 1'b1;
         // The faulting instruction itself is captured, then the stage freezes.
         if (stat_in != STAT_AOK) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q    <= STAT_AOK;
         icode_q   <= BUBBLE_ICODE;
         ifun_q    <= '0;
         cnd_q     <= 1'b0;
         rA_q      <= '0;
         rB_q      <= '0;
         vals_q    <= '0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         ctl_err_q <= 1'b0;
      end else begin
         stat_q    <= stat_d;
         icode_q   <= icode_d;
         ifun_q    <= ifun_d;
         cnd_q     <= cnd_d;
         rA_q      <= rA_d;
         rB_q      <= rB_d;
         vals_q    <= vals_d;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
         ctl_err_q <= ctl_err_d;
      end
   end

   assign stat_out    = stat_q;
   assign icode_out   = icode_q;
   assign ifun_out    = ifun_q;
   assign cnd_out     = cnd_q;
   assign rA_out      = rA_q;
   assign rB_out      = rB_q;
   assign vals_out    = vals_q;
   assign valid_out   = valid_q;
   assign halted_out  = halted_q;
   assign ctl_err_out = ctl_err_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Counters saturate at all-ones; halt freezes them via the decode above.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (do_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (do_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_out  = stall_cnt_q;
   assign bubble_cnt_out = bubble_cnt_q;
`else
   assign stall_cnt_out  = '0;
   assign bubble_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

   localparam int DATA_W  = 64;
   localparam int NUM_VAL = 6;
   localparam int REG_W   = 4;
   localparam int CNT_W   = 2;
   localparam int VW      = NUM_VAL * DATA_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall_in = 1'b0;
   logic             bubble_in = 1'b0;
   logic [2:0]       stat_in = 3'd1;
   logic [3:0]       icode_in = 4'h0;
   logic [3:0]       ifun_in = 4'h0;
   logic             cnd_in = 1'b0;
   logic [REG_W-1:0] rA_in = '0;
   logic [REG_W-1:0] rB_in = '0;
   logic [VW-1:0]    vals_in = '0;
   logic [2:0]       stat_out;
   logic [3:0]       icode_out;
   logic [3:0]       ifun_out;
   logic             cnd_out;
   logic [REG_W-1:0] rA_out;
   logic [REG_W-1:0] rB_out;
   logic [VW-1:0]    vals_out;
   logic             valid_out;
   logic             halted_out;
   logic             ctl_err_out;
   logic [CNT_W-1:0] stall_cnt_out;
   logic [CNT_W-1:0] bubble_cnt_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] exp_stall_sat;
   logic [1:0] exp_bub2;

   pipe_stage_reg #(
      .DATA_W(DATA_W), .NUM_VAL(NUM_VAL), .REG_W(REG_W),
      .BUBBLE_ICODE(4'h1), .STAT_AOK(3'd1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .bubble_in(bubble_in),
      .stat_in(stat_in), .icode_in(icode_in), .ifun_in(ifun_in),
      .cnd_in(cnd_in), .rA_in(rA_in), .rB_in(rB_in), .vals_in(vals_in),
      .stat_out(stat_out), .icode_out(icode_out), .ifun_out(ifun_out),
      .cnd_out(cnd_out), .rA_out(rA_out), .rB_out(rB_out),
      .vals_out(vals_out), .valid_out(valid_out), .halted_out(halted_out),
      .ctl_err_out(ctl_err_out), .stall_cnt_out(stall_cnt_out),
      .bubble_cnt_out(bubble_cnt_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] obs,
                        input logic [VW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VW-1:0] fld(input int k, input logic [DATA_W-1:0] v);
      logic [VW-1:0] r;
      r = '0;
      r[k*DATA_W +: DATA_W] = v;
      return r;
   endfunction

   task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                        input logic [3:0] fn, input logic c,
                        input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                        input logic [VW-1:0] v);
      stat_in = st; icode_in = ic; ifun_in = fn; cnd_in = c;
      rA_in = a; rB_in = b; vals_in = v;
   endtask

`ifdef PIPE_PERF_CNT_EN
   initial begin exp_stall_sat = 2'd3; exp_bub2 = 2'd2; end
`else
   initial begin exp_stall_sat = 2'd0; exp_bub2 = 2'd0; end
`endif

   initial begin
      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_stat", stat_out, 1);
      check("rst_icode", icode_out, 1);
      check("rst_vals", vals_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_halt", halted_out, 0);
      check("rst_err", ctl_err_out, 0);

      // Normal load, and no combinational path before the edge
      drive(3'd1, 4'h6, 4'h2, 1'b1, 4'd3, 4'd4, fld(0, 64'h5));
      #1;
      check("no_comb_path", icode_out, 1);
      tick();
      check("ld_icode", icode_out, 6);
      check("ld_ifun", ifun_out, 2);
      check("ld_cnd", cnd_out, 1);
      check("ld_rA", rA_out, 3);
      check("ld_rB", rB_out, 4);
      check("ld_vals", vals_out, fld(0, 64'h5));
      check("ld_valid", valid_out, 1);

      // Stall for 3 edges while inputs change
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(3'd1, 4'(4'h7 + i), 4'h0, 1'b0, 4'd9, 4'd9, fld(1, 64'(i + 100)));
         tick();
         check("stall_icode", icode_out, 6);
         check("stall_vals", vals_out, fld(0, 64'h5));
         check("stall_valid", valid_out, 1);
      end
      stall_in = 1'b0;

      // Bubble
      bubble_in = 1'b1;
      tick();
      bubble_in = 1'b0;
      check("bub_icode", icode_out, 1);
      check("bub_stat", stat_out, 1);
      check("bub_vals", vals_out, 0);
      check("bub_rA", rA_out, 0);
      check("bub_valid", valid_out, 0);
      check("bub_nohalt", halted_out, 0);

      // Simultaneous stall and bubble: hold, sticky error
      drive(3'd1, 4'h2, 4'h0, 1'b0, 4'd1, 4'd2, fld(1, 64'hABC));
      tick();
      drive(3'd1, 4'h5, 4'h0, 1'b0, 4'd0, 4'd0, fld(2, 64'h1));
      stall_in = 1'b1; bubble_in = 1'b1;
      tick();
      check("sb_icode", icode_out, 2);
      check("sb_vals", vals_out, fld(1, 64'hABC));
      check("sb_err", ctl_err_out, 1);
      stall_in = 1'b0; bubble_in = 1'b0;
      drive(3'd1, 4'h3, 4'h0, 1'b0, 4'd0, 4'd0, fld(3, 64'h33));
      tick();
      check("sb_err_sticky", ctl_err_out, 1);
      check("sb_next_icode", icode_out, 3);

      // Asynchronous reset with no clock edge
      rst = 1'b1;
      #2;
      check("arst_stat", stat_out, 1);
      check("arst_icode", icode_out, 1);
      check("arst_valid", valid_out, 0);
      check("arst_err", ctl_err_out, 0);
      check("arst_vals", vals_out, 0);
      check("arst_scnt", stall_cnt_out, 0);
      rst = 1'b0;

      // Counter saturation: 5 stalls, then 2 bubbles
      stall_in = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      stall_in = 1'b0;
      check("cnt_stall_sat", stall_cnt_out, exp_stall_sat);
      bubble_in = 1'b1;
      tick(); tick();
      bubble_in = 1'b0;
      check("cnt_bubble", bubble_cnt_out, exp_bub2);

      // Halt on non-AOK status
      drive(3'd2, 4'h0, 4'h0, 1'b0, 4'd5, 4'd6, fld(2, 64'h77));
      tick();
      check("hlt_halted", halted_out, 1);
      check("hlt_stat", stat_out, 2);
      check("hlt_icode", icode_out, 0);
      check("hlt_valid", valid_out, 1);
      drive(3'd1, 4'h9, 4'h1, 1'b1, 4'd1, 4'd1, fld(4, 64'h99));
      bubble_in = 1'b1;
      tick();
      bubble_in = 1'b0;
      check("hlt_hold_stat", stat_out, 2);
      check("hlt_hold_icode", icode_out, 0);
      check("hlt_hold_vals", vals_out, fld(2, 64'h77));
      check("hlt_hold_rA", rA_out, 5);
      check("hlt_hold_valid", valid_out, 1);
      check("hlt_bcnt_frozen", bubble_cnt_out, exp_bub2);
      stall_in = 1'b1;
      tick();
      stall_in = 1'b0;
      check("hlt_err_ignored", ctl_err_out, 0);
      check("hlt_scnt_frozen", stall_cnt_out, exp_stall_sat);
      tick();
      check("hlt_still", halted_out, 1);

      rst = 1'b1;
      #2;
      check("rel_halted", halted_out, 0);
      check("rel_stat", stat_out, 1);
      check("rel_bcnt", bubble_cnt_out, 0);
      rst = 1'b0;

      // Normal operation resumes after release
      drive(3'd1, 4'h4, 4'h0, 1'b0, 4'd2, 4'd3, fld(5, 64'hFEED));
      tick();
      check("resume_icode", icode_out, 4);
      check("resume_vals", vals_out, fld(5, 64'hFEED));
      check("resume_valid", valid_out, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
